// File: rtl/reg_bank_sequencer_if.sv
// reg_bank_sequencer_if -- signal bundle between the register-bank sequencer
// and its environment (command source, external register bank, byte sink).
//
// Signals:
//   start, mode, fillBase           command strobe, select (0 FILL / 1 DUMP), fill seed
//   busy, done                      sequencer status
//   readRegister1/2, readData1/2    bank read ports (data combinational from address)
//   writeRegister, writeData        bank write port (bank writes every rising edge)
//   outData, outValid, outReady     dump byte stream (valid/ready)
//
// Modports:
//   master  environment side (drives commands, bank read data, outReady)
//   slave   sequencer side
interface reg_bank_sequencer_if;
  logic       start;
  logic       mode;
  logic [7:0] fillBase;
  logic       busy;
  logic       done;
  logic [2:0] readRegister1;
  logic [2:0] readRegister2;
  logic [7:0] readData1;
  logic [7:0] readData2;
  logic [2:0] writeRegister;
  logic [7:0] writeData;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady;

  modport master (
    output start, mode, fillBase, readData1, readData2, outReady,
    input  busy, done, readRegister1, readRegister2, writeRegister, writeData,
           outData, outValid
  );

  modport slave (
    input  start, mode, fillBase, readData1, readData2, outReady,
    output busy, done, readRegister1, readRegister2, writeRegister, writeData,
           outData, outValid
  );
endinterface

// File: rtl/reg_bank_sequencer.sv
// reg_bank_sequencer -- fills an external 8x8 register bank with a seeded
// ramp, or dumps it as a byte stream over a valid/ready handshake.
//
// Ports:
//   clk   single clock, rising edge
//   rstN  synchronous active-low reset
//   bus   reg_bank_sequencer_if.slave (command, bank ports, byte stream)
//
// Optional feature: define SEQ_CHECKSUM_EN to append a running XOR of the
// eight dumped bytes as a 9th stream byte (SUM state).
//
// The bank has no write enable, so outside FILL the write port is parked on
// register 0 with data 0, which keeps register 0 a constant-zero register.
module reg_bank_sequencer (
  input  logic                 clk,
  input  logic                 rstN,
  reg_bank_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    DUMP_RD,
    DUMP_OUT0,
    DUMP_OUT1,
`ifdef SEQ_CHECKSUM_EN
    SUM,
`endif
    DONE
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] k_q, k_d;
  logic [1:0] p_q, p_d;
  logic [7:0] h0_q, h0_d;
  logic [7:0] h1_q, h1_d;
  logic [7:0] base_q, base_d;
`ifdef SEQ_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
`endif

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q <= IDLE;
      k_q     <= '0;
      p_q     <= '0;
      h0_q    <= '0;
      h1_q    <= '0;
      base_q  <= '0;
`ifdef SEQ_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      p_q     <= p_d;
      h0_q    <= h0_d;
      h1_q    <= h1_d;
      base_q  <= base_d;
`ifdef SEQ_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    p_d     = p_q;
    h0_d    = h0_q;
    h1_d    = h1_q;
    base_d  = base_q;
`ifdef SEQ_CHECKSUM_EN
    sum_d   = sum_q;
`endif

    bus.busy          = (state_q != IDLE);
    bus.done          = 1'b0;
    bus.readRegister1 = '0;
    bus.readRegister2 = '0;
    bus.writeRegister = '0;
    bus.writeData     = '0;
    bus.outData       = '0;
    bus.outValid      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (!bus.mode) begin
            state_d = FILL;
            k_d     = 3'd1;
            base_d  = bus.fillBase;
          end else begin
            state_d = DUMP_RD;
            p_d     = '0;
`ifdef SEQ_CHECKSUM_EN
            sum_d   = '0;
`endif
          end
        end
      end

      FILL: begin
        bus.writeRegister = k_q;
        bus.writeData     = base_q + {5'b0, k_q};
        if (k_q == 3'd7) state_d = DONE;
        else             k_d     = k_q + 3'd1;
      end

      DUMP_RD: begin
        bus.readRegister1 = {p_q, 1'b0};
        bus.readRegister2 = {p_q, 1'b1};
        h0_d    = bus.readData1;
        h1_d    = bus.readData2;
        state_d = DUMP_OUT0;
      end

      DUMP_OUT0: begin
        bus.outData  = h0_q;
        bus.outValid = 1'b1;
        if (bus.outReady) begin
          state_d = DUMP_OUT1;
`ifdef SEQ_CHECKSUM_EN
          sum_d   = sum_q ^ h0_q;
`endif
        end
      end

      DUMP_OUT1: begin
        bus.outData  = h1_q;
        bus.outValid = 1'b1;
        if (bus.outReady) begin
`ifdef SEQ_CHECKSUM_EN
          sum_d = sum_q ^ h1_q;
`endif
          if (p_q == 2'd3) begin
`ifdef SEQ_CHECKSUM_EN
            state_d = SUM;
`else
            state_d = DONE;
`endif
          end else begin
            p_d     = p_q + 2'd1;
            state_d = DUMP_RD;
          end
        end
      end

`ifdef SEQ_CHECKSUM_EN
      SUM: begin
        bus.outData  = sum_q;
        bus.outValid = 1'b1;
        if (bus.outReady) state_d = DONE;
      end
`endif

      DONE: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_bank_sequencer.sv
// tb_reg_bank_sequencer -- self-checking bench for reg_bank_sequencer.
// Holds the external register bank and an abstract model of its expected
// contents; dumps are compared against a byte list built from that model.
module tb_reg_bank_sequencer;

  logic clk = 1'b0;
  logic rstN;

  reg_bank_sequencer_if bus ();

  reg_bank_sequencer dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // External bank: written on every rising edge, read combinationally.
  logic [7:0] bank [8] = '{default: 8'h00};
  always_ff @(posedge clk) bank[bus.writeRegister] <= bus.writeData;
  assign bus.readData1 = bank[bus.readRegister1];
  assign bus.readData2 = bank[bus.readRegister2];

  // Expected bank contents after each completed command.
  logic [7:0] model [8] = '{default: 8'h00};

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_busy"},   bus.busy,          0);
    check_eq({tag, "_done"},   bus.done,          0);
    check_eq({tag, "_valid"},  bus.outValid,      0);
    check_eq({tag, "_data"},   bus.outData,       0);
    check_eq({tag, "_rr1"},    bus.readRegister1, 0);
    check_eq({tag, "_rr2"},    bus.readRegister2, 0);
    check_eq({tag, "_wreg"},   bus.writeRegister, 0);
    check_eq({tag, "_wdata"},  bus.writeData,     0);
  endtask

  task automatic run_fill(input logic [7:0] base, input bit poke);
    logic [7:0] e;
    bus.start = 1'b1; bus.mode = 1'b0; bus.fillBase = base;
    tick();
    // poke keeps start asserted through FILL and DONE; fillBase is scrambled
    // to confirm the seed was latched at start.
    bus.start = poke; bus.mode = 1'($urandom_range(0, 1)); bus.fillBase = 8'($urandom);
    for (int k = 1; k <= 7; k++) begin
      e = base + 8'(k);
      check_eq("fill_busy",  bus.busy,          1);
      check_eq("fill_wreg",  bus.writeRegister, k);
      check_eq("fill_wdata", bus.writeData,     e);
      tick();
    end
    check_eq("fill_done",      bus.done,          1);
    check_eq("fill_done_busy", bus.busy,          1);
    check_eq("fill_done_wreg", bus.writeRegister, 0);
    tick();
    bus.start = 1'b0;
    check_eq("fill_end_done", bus.done, 0);
    check_eq("fill_end_busy", bus.busy, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("fill_no_rerun", bus.busy, 0);
    end
    for (int k = 1; k <= 7; k++) model[k] = base + 8'(k);
  endtask

  task automatic run_dump(input bit stall3, input int unsigned ready_pct);
    logic [7:0] exp_q [$];
    logic [7:0] x;
    int unsigned idx, stall;
    bit seen_done, expect_valid;
    x = 8'h00;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(model[i]);
      x ^= model[i];
    end
`ifdef SEQ_CHECKSUM_EN
    exp_q.push_back(x);
`endif
    bus.outReady = 1'b0;
    bus.start = 1'b1; bus.mode = 1'b1;
    tick();
    bus.start = 1'b0;
    idx = 0; stall = 0; seen_done = 1'b0; expect_valid = 1'b0;
    for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
      if (expect_valid) check_eq("stall_valid", bus.outValid, 1);
      expect_valid = 1'b0;
      if (bus.done) begin
        seen_done = 1'b1;
        check_eq("dump_count", idx, exp_q.size());
      end else if (bus.outValid) begin
        if (idx < exp_q.size()) check_eq("dump_byte", bus.outData, exp_q[idx]);
        else                    check_eq("dump_extra", idx, exp_q.size());
        if (stall3 && idx == 3 && stall < 5) begin
          bus.outReady = 1'b0;
          stall++;
          expect_valid = 1'b1;
        end else if (stall3 && idx == 3) begin
          bus.outReady = 1'b1;
        end else begin
          bus.outReady = ($urandom_range(0, 99) < ready_pct);
        end
        if (bus.outReady) idx++;
        tick();
      end else begin
        check_eq("dump_gap_data", bus.outData, 0);
        bus.outReady = 1'($urandom_range(0, 1));
        tick();
      end
    end
    check_eq("dump_timeout", seen_done, 1);
    if (stall3) check_eq("stall_len", stall, 5);
    bus.outReady = 1'b0;
    tick();
    check_eq("dump_end_busy", bus.busy, 0);
  endtask

  task automatic abort_fill(input logic [7:0] base);
    logic [7:0] old [8];
    old = model;
    bus.start = 1'b1; bus.mode = 1'b0; bus.fillBase = base;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check_eq("abort_k4", bus.writeRegister, 4);
    rstN = 1'b0;
    tick();
    check_eq("abort_busy",  bus.busy,          0);
    check_eq("abort_wreg",  bus.writeRegister, 0);
    check_eq("abort_wdata", bus.writeData,     0);
    tick();
    check_quiet("abort_in_reset");
    rstN = 1'b1;
    tick();
    tick();
    check_eq("abort_no_resume", bus.busy, 0);
    for (int k = 1; k <= 3; k++) check_eq("abort_written", bank[k], 8'(base + 8'(k)));
    for (int k = 5; k <= 7; k++) check_eq("abort_untouched", bank[k], old[k]);
  endtask

  task automatic abort_stall();
    bus.outReady = 1'b0;
    bus.start = 1'b1; bus.mode = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check_eq("stallrst_valid", bus.outValid, 1);
    check_eq("stallrst_byte0", bus.outData,  model[0]);
    rstN = 1'b0;
    tick();
    check_quiet("stallrst");
    rstN = 1'b1;
    tick();
    tick();
    check_eq("stallrst_no_resume", bus.busy, 0);
  endtask

  initial begin
    rstN = 1'b0;
    bus.start = 1'b0; bus.mode = 1'b0; bus.fillBase = 8'h00; bus.outReady = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check_quiet("reset");
    rstN = 1'b1;
    tick();
    check_quiet("post_reset");

    run_fill(8'h10, 1'b0);
    run_dump(1'b0, 100);
    run_dump(1'b1, 100);

    run_fill(8'hFC, 1'b1);
    check_eq("wrap_reg7", bank[7], 8'h03);
    run_dump(1'b0, 60);

    abort_fill(8'h5A);
    run_fill(8'($urandom), 1'b0);
    abort_stall();
    run_dump(1'b1, 70);

    for (int r = 0; r < 6; r++) begin
      run_fill(8'($urandom), 1'($urandom_range(0, 1)));
      run_dump(1'($urandom_range(0, 1)), $urandom_range(30, 100));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reg_bank_sequencer.md
REG_BANK_SEQUENCER -- requirements
Module: reg_bank_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rstN  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: start  input  1  command strobe, sampled in IDLE only.
REQ-004 SHALL have port: mode  input  1  command select: 0 = FILL, 1 = DUMP; sampled with start.
REQ-005 SHALL have port: fillBase  input  8  fill seed; register k receives fillBase+k.
REQ-006 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-007 SHALL have port: done  output  1  one-cycle pulse on command completion.
REQ-008 SHALL have ports: readRegister1, readRegister2  output  3 each  bank read addresses.
REQ-009 SHALL have ports: readData1, readData2  input  8 each  bank read data, combinational from the addresses.
REQ-010 SHALL have ports: writeRegister  output  3, writeData  output  8  bank write port; the bank writes on every rising edge and has no enable.
REQ-011 SHALL have ports: outData  output  8, outValid  output  1, outReady  input  1  dump byte stream.

Function
REQ-012 SHALL implement states IDLE, FILL, DUMP_RD, DUMP_OUT0, DUMP_OUT1, SUM, DONE.
REQ-013 SHALL, outside FILL, drive writeRegister=0 and writeData=0, making register 0 the zero/sink register.
REQ-014 SHALL, in IDLE, move on start=1 to FILL when mode=0, or to DUMP_RD when mode=1, on the next edge.
REQ-015 SHALL ignore start whenever busy=1.
REQ-016 SHALL, in FILL, step k from 1 to 7, one per cycle, driving writeRegister=k and writeData=(fillBase+k) mod 256; fillBase is latched at start.
REQ-017 SHALL, after the k=7 cycle, enter DONE; FILL therefore lasts exactly 7 cycles.
REQ-018 SHALL, in DUMP_RD with pair index p (0..3), drive readRegister1=2p and readRegister2=2p+1, capture readData1 and readData2 into holding registers h0 and h1 in one cycle, then go to DUMP_OUT0.
REQ-019 SHALL, in DUMP_OUT0, present outData=h0 with outValid=1; on outReady=1 go to DUMP_OUT1.
REQ-020 SHALL, in DUMP_OUT1, present outData=h1 with outValid=1; on outReady=1 go to DUMP_RD with p+1, or, if p=3, go to SUM (macro defined) or DONE (macro undefined).
REQ-021 SHALL hold outData stable while outValid=1 and outReady=0; stalls of any length are allowed.
REQ-022 SHALL drive outValid=0 and outData=0 in every state except DUMP_OUT0, DUMP_OUT1 and SUM.
REQ-023 SHALL stream bytes in register order 0..7; register 0 always reads 0.
REQ-024 SHALL, in DONE, assert done=1 and busy=1 for one cycle, then return to IDLE; a start seen in DONE is ignored.
REQ-025 SHALL hold readRegister1/2 at 0 outside DUMP_RD.

Reset
REQ-026 SHALL, on a rising edge with rstN=0, enter IDLE and clear p, k, h0, h1 and the checksum, from any state, including mid-FILL or mid-stall.
REQ-027 SHALL hold these output values during and after reset: busy=0, done=0, outValid=0, outData=0, and 0 on all address and write-data ports.
REQ-028 SHALL NOT resume an aborted command after reset; bank contents already written are not restored.

Configuration
REQ-029 SHALL, with SEQ_CHECKSUM_EN defined, keep a running 8-bit XOR of every dumped byte, cleared at start, and emit it in SUM as a 9th byte with the same valid/ready rule before DONE.
REQ-030 SHALL, without SEQ_CHECKSUM_EN, have no SUM state and no checksum logic; a dump is exactly 8 bytes.

Verification
REQ-031 SHALL cover: reset, then start with mode=0 and fillBase=0x10 -> writes (1,0x11)...(7,0x17) on 7 consecutive cycles, then done for one cycle.
REQ-032 SHALL cover: FILL, then start with mode=1 and outReady held 1 -> stream 0x00,0x11,0x12,...,0x17; with the macro, 9th byte = XOR = 0x00^0x11^...^0x17.
REQ-033 SHALL cover: DUMP with outReady low for 5 cycles on byte 3 -> outData=0x13 held steady and outValid=1 for the whole stall, with no byte lost or duplicated.
REQ-034 SHALL cover: fillBase=0xFC -> reg7 = 0x03 (wrap-around mod 256).
REQ-035 SHALL cover: start pulsed during FILL and during DONE -> ignored, with no extra command run.
REQ-036 SHALL cover: rstN=0 at FILL cycle k=4 -> IDLE next edge, busy=0, writeRegister=0, with no further writes.
